// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter
// Sole owner of the register-file write port. Two writeback requesters
// (A = ALU, B = load unit) share the port with round-robin fairness. A
// clear sequencer zeroes every register after reset or on request,
// because the register file itself has no reset. Writes to register 0
// are accepted but never reach the port.
module reg_file_wr_arbiter #(
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wr_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX    = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA   = {DATA_W{1'b0}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              last_b_q, last_b_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              acc_a_s;
  logic              acc_b_s;

  // Grant selection: readies depend only on state, clear_req, valids and last_b.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if ((state_q == ST_RUN) && !clear_req) begin
      if (a_valid && b_valid) begin
        // Alternate under contention: B gets priority unless B won last time.
        if (last_b_q) begin
          a_ready = 1'b1;
        end else begin
          b_ready = 1'b1;
        end
      end else if (b_valid) begin
        b_ready = 1'b1;
      end else begin
        // Only A valid, or idle: A's ready is allowed high without a request.
        a_ready = 1'b1;
      end
    end else begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  assign acc_a_s = a_valid & a_ready;
  assign acc_b_s = b_valid & b_ready;

  // Next-state, clear sequencing and write-port register inputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_b_d = last_b_q;
    wr_en_d  = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d = 1'b1;
        rd_d    = idx_q;
        data_d  = ZERO_DATA;
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = ZERO_IDX;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = ZERO_IDX;
        end else if (acc_b_s) begin
          last_b_d = 1'b1;
          // Register 0 is hardwired: accept the handshake, suppress the write.
          if (b_rd != ZERO_IDX) begin
            wr_en_d = 1'b1;
            rd_d    = b_rd;
            data_d  = b_data;
          end else begin
            wr_en_d = 1'b0;
          end
        end else if (acc_a_s) begin
          last_b_d = 1'b0;
          if (a_rd != ZERO_IDX) begin
            wr_en_d = 1'b1;
            rd_d    = a_rd;
            data_d  = a_data;
          end else begin
            wr_en_d = 1'b0;
          end
        end else begin
          wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_STATE;
        idx_d   = ZERO_IDX;
      end
    endcase
  end

  // State, arbitration history and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RESET_STATE;
      idx_q    <= ZERO_IDX;
      last_b_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_q     <= ZERO_IDX;
      data_q   <= ZERO_DATA;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_b_q <= last_b_d;
      wr_en_q  <= wr_en_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign rf_wr_en   = wr_en_q;
  assign rf_rd      = rd_q;
  assign rf_wr_data = data_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// tb_reg_file_wr_arbiter
// Scenario tasks drive stimulus on the falling edge and push every write
// they expect into a queue; a falling-edge monitor pops and compares each
// write the DUT issues, so a missing, extra or out-of-order write is seen.
module tb_reg_file_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          clear_req;
  logic          busy;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wr_data;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic exp_last_b;

  reg_file_wr_arbiter #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every issued write must match the oldest expectation.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst && rf_wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({rf_rd, rf_wr_data} !== e) begin
          bad++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_wr_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back({AW'(i), {DW{1'b0}}});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_req = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    exp_q.delete();
    exp_last_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({rf_wr_en, rf_rd, rf_wr_data} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_outputs: got en=%b rd=%0d data=%h, required 0/0/0", rf_wr_en, rf_rd, rf_wr_data);
    end
    total++;
    if ({busy, a_ready, b_ready} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: got busy/a_ready/b_ready=%b, required 100", {busy, a_ready, b_ready});
    end
  endtask

  task automatic test_clear_after_reset();
    int busy_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    push_clear();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    #1;
    total++;
    if (busy_cnt !== NR) begin
      bad++;
      $display("FAIL clear_busy_len: got %0d cycles, required %0d", busy_cnt, NR);
    end
    total++;
    if (exp_q.size() != 0 || rf_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL clear_drain: got pending=%0d en=%b, required 0/0", exp_q.size(), rf_wr_en);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready: got a/b=%b, required 10", {a_ready, b_ready});
    end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    exp_last_b = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    total++;
    if ({rf_wr_en, rf_rd, rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL single_write: got en=%b rd=%0d data=%h, required 1/5/deadbeef", rf_wr_en, rf_rd, rf_wr_data);
    end
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL idle_ready: got a/b=%b, required 10", {a_ready, b_ready});
    end
  endtask

  task automatic test_contention();
    logic gb;
    logic [AW-1:0] na = 5'd1;
    logic [AW-1:0] nb = 5'd17;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_rd = na; a_data = 32'hA000_0000 + 32'(na);
      b_valid = 1'b1; b_rd = nb; b_data = 32'hB000_0000 + 32'(nb);
      #1;
      gb = ~exp_last_b;
      total++;
      if ({a_ready, b_ready} !== {~gb, gb}) begin
        bad++;
        $display("FAIL contend_grant%0d: got a/b=%b, required %b", i, {a_ready, b_ready}, {~gb, gb});
      end
      if (gb) begin
        exp_q.push_back({nb, 32'hB000_0000 + 32'(nb)});
        nb = nb + 5'd1;
      end else begin
        exp_q.push_back({na, 32'hA000_0000 + 32'(na)});
        na = na + 5'd1;
      end
      exp_last_b = gb;
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL contend_drain: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reg0_write();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h0000_1234;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL reg0_ready: got a_ready=%b, required 1", a_ready);
    end
    exp_last_b = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    total++;
    if (rf_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reg0_dropped: got en=%b, required 0", rf_wr_en);
    end
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3333_3333;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h4444_4444;
    #1;
    total++;
    if ({a_ready, b_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reg0_next_grant: got a/b=%b, required 01", {a_ready, b_ready});
    end
    exp_q.push_back({5'd4, 32'h4444_4444});
    exp_last_b = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reg0_a_after_b: got a/b=%b, required 10", {a_ready, b_ready});
    end
    exp_q.push_back({5'd3, 32'h3333_3333});
    exp_last_b = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_clear_req();
    int busy_cnt = 0;
    bit accepted = 1'b0;
    @(negedge clk);
    clear_req = 1'b1;
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'hCAFE_F00D;
    #1;
    total++;
    if ({a_ready, b_ready, busy} !== 3'b000) begin
      bad++;
      $display("FAIL clrreq_block: got a/b/busy=%b, required 000", {a_ready, b_ready, busy});
    end
    @(negedge clk);
    clear_req = 1'b0;
    push_clear();
    for (int i = 0; i < 40 && !accepted; i++) begin
      #1;
      total++;
      if (busy) begin
        busy_cnt++;
        if (a_ready !== 1'b0) begin
          bad++;
          $display("FAIL clrreq_ready_busy: got a_ready=%b at cycle %0d, required 0", a_ready, i);
        end
      end else begin
        accepted = 1'b1;
        if (a_ready !== 1'b1 || busy_cnt != NR) begin
          bad++;
          $display("FAIL clrreq_first_run: got a_ready=%b busy_cycles=%0d, required 1/%0d", a_ready, busy_cnt, NR);
        end
        exp_q.push_back({5'd9, 32'hCAFE_F00D});
        exp_last_b = 1'b0;
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    #1;
    total++;
    if (!accepted || {rf_wr_en, rf_rd} !== {1'b1, 5'd9} || exp_q.size() != 0) begin
      bad++;
      $display("FAIL clrreq_a_write: got accepted=%b en=%b rd=%0d pending=%0d, required 1/1/9/0",
               accepted, rf_wr_en, rf_rd, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_last_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_clear();
    repeat (11) @(negedge clk);
    #1;
    total++;
    if ({rf_wr_en, rf_rd} !== {1'b1, 5'd10}) begin
      bad++;
      $display("FAIL midclr_position: got en=%b rd=%0d, required 1/10", rf_wr_en, rf_rd);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({rf_wr_en, rf_rd, rf_wr_data} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
      bad++;
      $display("FAIL midclr_async_reset: got en=%b rd=%0d data=%h, required 0/0/0", rf_wr_en, rf_rd, rf_wr_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_clear();
    @(negedge clk);
    #1;
    total++;
    if ({rf_wr_en, rf_rd} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL midclr_restart: got en=%b rd=%0d, required 1/0", rf_wr_en, rf_rd);
    end
    repeat (32) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || rf_wr_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midclr_complete: got pending=%0d en=%b busy=%b, required 0/0/0", exp_q.size(), rf_wr_en, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clear_after_reset();
    test_single_write();
    test_contention();
    test_reg0_write();
    test_clear_req();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the whole run so a stuck DUT still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
